ps2_token_decoder: RTL and testbench
====================================

# ps2_token_decoder

Receives PS/2 keyboard frames and converts key presses into calculator tokens. It sits directly upstream of the digit-accumulation stage: digit tokens plus a one-cycle digit strobe drive number building, and operator, enter and clear events go to the stack and control logic. It handles line synchronisation, clock filtering, frame checking, break and extended prefixes, and scan-code mapping.

## Interface
- FILTER_LEN, 8: consecutive equal samples needed before the filtered ps2_clk level changes.
- TIMEOUT, 50000: clk cycles without a filtered ps2_clk falling edge before a partial frame is aborted.
- clk  in  1  system clock; every register is on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ps2_clk  in  1  PS/2 clock line, asynchronous.
- ps2_data  in  1  PS/2 data line, asynchronous.
- token  out  4  last token: 0–9 digit, 10 '+', 11 '-', 12 '*', 13 '/'.
- digit_strobe  out  1  one-cycle pulse; token holds a digit 0–9.
- op_strobe  out  1  one-cycle pulse; token holds an operator 10–13.
- enter_strobe  out  1  one-cycle pulse for Enter or '='.
- clear_strobe  out  1  one-cycle pulse for Backspace or Esc.
- frame_err  out  1  one-cycle pulse for a bad start bit, parity, stop bit or timeout.

## Operation
- **Reset state:** token=0, all strobes=0, frame_err=0, FSM=IDLE, ext=0, brk=0. Filtered clk=1. Synchronisers are preset to 1.
- **Input conditioning:**
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - The filtered clk takes the synchronised level only after FILTER_LEN identical consecutive samples.
  - A 1→0 transition of the filtered clk is a "sample edge". ps2_data is sampled on that cycle.
- **Frame FSM:** states IDLE → DATA → PARITY → STOP → IDLE.
  - IDLE: on a sample edge, data=0 moves to DATA with bit count 0. data=1 is ignored and the FSM stays in IDLE.
  - DATA: shift in 8 bits, LSB first, then go to PARITY.
  - PARITY: store the bit, then go to STOP.
  - STOP: the frame is valid if stop=1 and the 9 bits (data plus parity) have odd parity. Then return to IDLE.
  - An invalid frame pulses frame_err and the byte is discarded.
  - In any non-IDLE state, an idle counter increments every cycle and clears on each sample edge. When it reaches TIMEOUT: go to IDLE, pulse frame_err, and leave ext and brk unchanged.
- **Byte layer** (valid bytes only):
  - 0xE0 sets ext. 0xF0 sets brk. Neither produces output.
  - Any other byte with brk=1 is a key release: no output, and ext and brk both clear.
  - Any other byte with brk=0 is mapped as below, then ext clears.
- **Mapping with ext=0:**
  - Digits 0–9: 0x45, 0x16, 0x1E, 0x26, 0x25, 0x2E, 0x36, 0x3D, 0x3E, 0x46 (main row).
  - Digits 0–9: 0x70, 0x69, 0x72, 0x7A, 0x6B, 0x73, 0x74, 0x6C, 0x75, 0x7D (keypad).
  - Operators: 0x79→10, 0x7B→11, 0x7C→12.
  - Enter: 0x5A or 0x55.
  - Clear: 0x66 or 0x76.
- **Mapping with ext=1:** 0x4A→13 and 0x5A→enter. Every other extended code is ignored.
- Unmapped codes produce no output and no error.
- Typematic repeats (repeated make codes) each produce a fresh strobe. There is no held-key suppression.
- At most one of the four strobes is high in any cycle.
- token updates only when digit_strobe or op_strobe fires, and holds between events. Enter and clear leave token unchanged.

## Timing
- Latency: a strobe or frame_err is high exactly on cycle N+1, where N is the cycle in which the stop-bit sample edge is detected.
- A timeout error is high on the cycle after the counter reaches TIMEOUT.
- Input-pin-to-filtered-edge delay is 2 + FILTER_LEN cycles. Glitches shorter than FILTER_LEN cycles are rejected.
- No back-pressure: consumers must accept a strobe in the cycle it occurs. The minimum spacing between events is one PS/2 frame, ≥ 11 PS/2 clocks.
- Reset mid-frame: all state clears immediately. The next frame is decoded only after a start bit seen from IDLE.
- A sample edge coinciding with TIMEOUT: the edge wins, the counter clears and no error is raised.

## Test plan
- Frame 0x16 with parity 0 and stop 1 → token=1, digit_strobe high for exactly one cycle on N+1. No other strobe, frame_err=0.
- Sequence 0x3D, 0xF0, 0x3D, 0x7C → digit_strobe with token=7, then op_strobe with token=12. The release produces nothing.
- Sequence 0xE0, 0x4A, then 0xE0, 0xF0, 0x4A → one op_strobe with token=13. Afterwards ext=0 and brk=0. Then 0x4A alone produces no output.
- Frame 0x5A with a wrong parity bit → frame_err pulse, no strobe. Frame 0x5A with stop=0 → frame_err. A correct 0x5A → enter_strobe, token unchanged.
- Stop toggling ps2_clk after 4 data bits for TIMEOUT cycles → one frame_err pulse and FSM in IDLE. A following valid 0x76 → clear_strobe.
- Inject ps2_clk glitches of FILTER_LEN-1 cycles during IDLE → no FSM activity. Assert rst_n low mid-frame → all outputs 0, and the next full 0x45 frame → digit_strobe with token=0.

Source files
------------

// File: rtl/ps2_token_decoder.sv
// rtl/ps2_token_decoder.sv - PS/2 keyboard frame receiver and calculator token decoder
//
// Purpose: synchronises and filters the PS/2 lines, receives 11-bit frames,
// handles E0/F0 prefixes and maps make codes onto calculator tokens.
//
// Ports:
//   clk           in   system clock, all registers on its rising edge
//   rst_n         in   asynchronous active-low reset
//   ps2_clk       in   PS/2 clock line (asynchronous)
//   ps2_data      in   PS/2 data line (asynchronous)
//   token         out  last digit (0-9) or operator (10-13) token
//   digit_strobe  out  one-cycle pulse, token holds a digit
//   op_strobe     out  one-cycle pulse, token holds an operator
//   enter_strobe  out  one-cycle pulse for Enter / '='
//   clear_strobe  out  one-cycle pulse for Backspace / Esc
//   frame_err     out  one-cycle pulse for start/parity/stop/timeout errors
module ps2_token_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] token,
  output logic       digit_strobe,
  output logic       op_strobe,
  output logic       enter_strobe,
  output logic       clear_strobe,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam logic [2:0] K_NONE  = 3'd0;
  localparam logic [2:0] K_DIGIT = 3'd1;
  localparam logic [2:0] K_OP    = 3'd2;
  localparam logic [2:0] K_ENTER = 3'd3;
  localparam logic [2:0] K_CLEAR = 3'd4;

  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           filt_q;
  logic [FCW-1:0] filt_cnt_q;
  logic [1:0]     state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] idle_cnt_q, idle_cnt_d;
  logic           ext_q, ext_d, brk_q, brk_d;
  logic [3:0]     token_q, token_d;
  logic           dig_q, dig_d, op_q, op_d, ent_q, ent_d, clr_q, clr_d, err_q, err_d;

  logic           differ, flip, sample;
  logic [2:0]     map_kind;
  logic [3:0]     map_tok;

  // The filtered level flips on the FILTER_LEN-th consecutive differing
  // sample; a falling flip is the sample edge, seen in the same cycle.
  assign differ = (clk_s2_q != filt_q);
  assign flip   = differ && (filt_cnt_q == FCW'(FILTER_LEN - 1));
  assign sample = flip && filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      if (!differ || flip) filt_cnt_q <= '0;
      else                 filt_cnt_q <= filt_cnt_q + 1'b1;
      if (flip) filt_q <= ~filt_q;
    end
  end

  always_comb begin
    map_kind = K_NONE;
    map_tok  = 4'd0;
    if (!ext_q) begin
      case (shift_q)
        8'h45, 8'h70: begin map_kind = K_DIGIT; map_tok = 4'd0; end
        8'h16, 8'h69: begin map_kind = K_DIGIT; map_tok = 4'd1; end
        8'h1E, 8'h72: begin map_kind = K_DIGIT; map_tok = 4'd2; end
        8'h26, 8'h7A: begin map_kind = K_DIGIT; map_tok = 4'd3; end
        8'h25, 8'h6B: begin map_kind = K_DIGIT; map_tok = 4'd4; end
        8'h2E, 8'h73: begin map_kind = K_DIGIT; map_tok = 4'd5; end
        8'h36, 8'h74: begin map_kind = K_DIGIT; map_tok = 4'd6; end
        8'h3D, 8'h6C: begin map_kind = K_DIGIT; map_tok = 4'd7; end
        8'h3E, 8'h75: begin map_kind = K_DIGIT; map_tok = 4'd8; end
        8'h46, 8'h7D: begin map_kind = K_DIGIT; map_tok = 4'd9; end
        8'h79:        begin map_kind = K_OP;    map_tok = 4'd10; end
        8'h7B:        begin map_kind = K_OP;    map_tok = 4'd11; end
        8'h7C:        begin map_kind = K_OP;    map_tok = 4'd12; end
        8'h5A, 8'h55: map_kind = K_ENTER;
        8'h66, 8'h76: map_kind = K_CLEAR;
        default:      map_kind = K_NONE;
      endcase
    end else begin
      case (shift_q)
        8'h4A:   begin map_kind = K_OP; map_tok = 4'd13; end
        8'h5A:   map_kind = K_ENTER;
        default: map_kind = K_NONE;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    idle_cnt_d = idle_cnt_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    token_d    = token_q;
    dig_d      = 1'b0;
    op_d       = 1'b0;
    ent_d      = 1'b0;
    clr_d      = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        idle_cnt_d = '0;
        if (sample && !dat_s2_q) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (sample) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (sample) begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
      end
      default: begin
        if (sample) begin
          state_d = S_IDLE;
          if (dat_s2_q && (^{shift_q, par_q})) begin
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else if (brk_q) begin
              ext_d = 1'b0;
              brk_d = 1'b0;
            end else begin
              ext_d = 1'b0;
              case (map_kind)
                K_DIGIT: begin dig_d = 1'b1; token_d = map_tok; end
                K_OP:    begin op_d  = 1'b1; token_d = map_tok; end
                K_ENTER: ent_d = 1'b1;
                K_CLEAR: clr_d = 1'b1;
                default: ;
              endcase
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase

    // Stall watchdog for partial frames; a coincident sample edge wins.
    if (state_q != S_IDLE) begin
      if (sample) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q == TCW'(TIMEOUT)) begin
        state_d    = S_IDLE;
        err_d      = 1'b1;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      idle_cnt_q <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      token_q    <= '0;
      dig_q      <= 1'b0;
      op_q       <= 1'b0;
      ent_q      <= 1'b0;
      clr_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      idle_cnt_q <= idle_cnt_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      token_q    <= token_d;
      dig_q      <= dig_d;
      op_q       <= op_d;
      ent_q      <= ent_d;
      clr_q      <= clr_d;
      err_q      <= err_d;
    end
  end

  assign token        = token_q;
  assign digit_strobe = dig_q;
  assign op_strobe    = op_q;
  assign enter_strobe = ent_q;
  assign clear_strobe = clr_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_ps2_token_decoder.sv
// tb/tb_ps2_token_decoder.sv - directed self-checking bench for ps2_token_decoder
module tb_ps2_token_decoder;

  localparam int FLEN = 8;
  localparam int TOUT = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] token;
  logic       digit_strobe, op_strobe, enter_strobe, clear_strobe, frame_err;

  ps2_token_decoder #(.FILTER_LEN(FLEN), .TIMEOUT(TOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .token        (token),
    .digit_strobe (digit_strobe),
    .op_strobe    (op_strobe),
    .enter_strobe (enter_strobe),
    .clear_strobe (clear_strobe),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: cumulative pulse counts, one-hot and pulse-width tracking.
  int n_dig = 0, n_op = 0, n_ent = 0, n_clr = 0, n_err = 0;
  int onehot_viol = 0, width_viol = 0, last_evt_cyc = 0;
  logic [4:0] prev_ev = '0;
  always @(negedge clk) begin
    logic [4:0] ev;
    ev = {frame_err, clear_strobe, enter_strobe, op_strobe, digit_strobe};
    if ((int'(ev[0]) + int'(ev[1]) + int'(ev[2]) + int'(ev[3])) > 1) onehot_viol++;
    if ((ev & prev_ev) != 5'd0) width_viol++;
    if ((ev & ~prev_ev) != 5'd0) last_evt_cyc = cyc;
    if (ev[0]) n_dig++;
    if (ev[1]) n_op++;
    if (ev[2]) n_ent++;
    if (ev[3]) n_clr++;
    if (ev[4]) n_err++;
    prev_ev = ev;
  end

  int b_dig, b_op, b_ent, b_clr, b_err, t_stop;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_dig = n_dig; b_op = n_op; b_ent = n_ent; b_clr = n_clr; b_err = n_err;
  endtask

  task automatic expect_events(input string tag, input int d, input int o, input int e,
                               input int c, input int r);
    check_val({tag, ".digit"}, n_dig - b_dig, d);
    check_val({tag, ".op"},    n_op  - b_op,  o);
    check_val({tag, ".enter"}, n_ent - b_ent, e);
    check_val({tag, ".clear"}, n_clr - b_clr, c);
    check_val({tag, ".err"},   n_err - b_err, r);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the first nbits of a frame: start, 8 data LSB first, parity, stop.
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit stop_v,
                           input int nbits);
    logic [10:0] f;
    f = {stop_v, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      if (i == 10) t_stop = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 1'b0, 1'b1, 11);
  endtask

  initial begin
    wait_cyc(3);
    check_val("rst.token", token, 0);
    check_val("rst.strobes", {digit_strobe, op_strobe, enter_strobe, clear_strobe}, 0);
    check_val("rst.err", frame_err, 0);
    rst_n = 1'b1;
    wait_cyc(30);
    check_val("idle.token", token, 0);
    check_val("idle.err", frame_err, 0);

    // Single make code with latency measurement.
    snap();
    send(8'h16);
    expect_events("k1", 1, 0, 0, 0, 0);
    check_val("k1.token", token, 1);
    check_val("k1.latency", last_evt_cyc - t_stop, FLEN + 2);

    // Make, release, operator.
    snap(); send(8'h3D);
    expect_events("k7", 1, 0, 0, 0, 0);
    check_val("k7.token", token, 7);
    snap(); send(8'hF0); send(8'h3D);
    expect_events("k7rel", 0, 0, 0, 0, 0);
    check_val("k7rel.token", token, 7);
    snap(); send(8'h7C);
    expect_events("mul", 0, 1, 0, 0, 0);
    check_val("mul.token", token, 12);

    // Extended divide, its release, then bare 0x4A.
    snap(); send(8'hE0); send(8'h4A);
    expect_events("div", 0, 1, 0, 0, 0);
    check_val("div.token", token, 13);
    snap(); send(8'hE0); send(8'hF0); send(8'h4A); send(8'h4A);
    expect_events("divrel", 0, 0, 0, 0, 0);

    // Enter with bad parity, bad stop, then valid.
    snap(); send_bits(8'h5A, 1'b1, 1'b1, 11);
    expect_events("badpar", 0, 0, 0, 0, 1);
    snap(); send_bits(8'h5A, 1'b0, 1'b0, 11);
    expect_events("badstop", 0, 0, 0, 0, 1);
    snap(); send(8'h5A);
    expect_events("enter", 0, 0, 1, 0, 0);
    check_val("enter.token", token, 13);

    // Stall after 4 data bits, then a clear key.
    snap(); send_bits(8'h16, 1'b0, 1'b1, 5);
    wait_cyc(TOUT + 100);
    expect_events("tout", 0, 0, 0, 0, 1);
    snap(); send(8'h76);
    expect_events("clr", 0, 0, 0, 1, 0);

    // Short clock glitches with data low must not start a frame.
    snap();
    ps2_data = 1'b0;
    for (int g = 0; g < 5; g++) begin
      ps2_clk = 1'b0;
      wait_cyc(FLEN - 1);
      ps2_clk = 1'b1;
      wait_cyc(FLEN + 4);
    end
    ps2_data = 1'b1;
    wait_cyc(20);
    expect_events("glitch", 0, 0, 0, 0, 0);
    snap(); send(8'h1E);
    expect_events("postglitch", 1, 0, 0, 0, 0);
    check_val("postglitch.token", token, 2);

    // Reset in the middle of a frame.
    send_bits(8'h46, 1'b0, 1'b1, 4);
    rst_n = 1'b0;
    wait_cyc(2);
    check_val("midrst.token", token, 0);
    check_val("midrst.outs", {digit_strobe, op_strobe, enter_strobe, clear_strobe, frame_err}, 0);
    rst_n = 1'b1;
    wait_cyc(30);
    snap(); send(8'h45);
    expect_events("k0", 1, 0, 0, 0, 0);
    check_val("k0.token", token, 0);

    check_val("onehot", onehot_viol, 0);
    check_val("width", width_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
